// File: rtl/image_load_controller.sv
// Image load controller: streams IMG_BYTES bytes into an image buffer, starts
// the BNN, waits (with timeout) for its result and holds it until acknowledged.
module image_load_controller #(
    parameter int IMG_BYTES      = 113,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    input  logic       cmd_clear,
    output logic       buf_clear,
    output logic       buf_we,
    output logic [7:0] buf_data,
    output logic       bnn_start,
    input  logic       bnn_done,
    input  logic [3:0] bnn_result,
    output logic [3:0] result,
    output logic       result_valid,
    input  logic       result_ack,
    output logic       err_timeout,
    output logic [6:0] byte_count,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        ST_CLEAR  = 3'd0,
        ST_LOAD   = 3'd1,
        ST_START  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_RESULT = 3'd4
    } state_t;

    localparam logic [6:0]  LAST_BYTE = 7'(IMG_BYTES - 1);
    localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [6:0]  byte_count_q, byte_count_d;
    logic [3:0]  result_q, result_d;
    logic        result_valid_q, result_valid_d;
    logic        err_timeout_q, err_timeout_d;
    logic [15:0] timeout_cnt_q, timeout_cnt_d;
    logic        accept;

    // Handshake: a byte transfers on any cycle where rx_valid && rx_ready;
    // rx_ready is only offered in LOAD, never during reset or a clear request.
    assign rx_ready  = !rst && (state_q == ST_LOAD) && !cmd_clear;
    assign accept    = rx_valid && rx_ready;
    assign buf_we    = accept;
    assign buf_data  = rx_data;
    assign buf_clear = rst || (state_q == ST_CLEAR);
    assign bnn_start = !rst && (state_q == ST_START);

    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign err_timeout  = err_timeout_q;
    assign byte_count   = byte_count_q;
    assign state_o      = state_q;

    always_comb begin
        state_d        = state_q;
        byte_count_d   = byte_count_q;
        result_d       = result_q;
        err_timeout_d  = err_timeout_q;
        timeout_cnt_d  = timeout_cnt_q;

        case (state_q)
            ST_CLEAR:  state_d = ST_LOAD;
            ST_LOAD: begin
                if (accept && (byte_count_q == LAST_BYTE)) begin
                    state_d = ST_START;
                end
            end
            ST_START:  state_d = ST_WAIT;
            ST_WAIT: begin
                // A done arriving on the final allowed cycle beats the timeout.
                if (bnn_done) begin
                    state_d = ST_RESULT;
                end else if (timeout_cnt_q == TO_LAST) begin
                    state_d       = ST_CLEAR;
                    err_timeout_d = 1'b1;
                end
            end
            ST_RESULT: begin
                if (result_ack) begin
                    state_d = ST_CLEAR;
                end
            end
            default:   state_d = ST_CLEAR;
        endcase

        if (cmd_clear) begin
            state_d       = ST_CLEAR;
            err_timeout_d = 1'b0;
        end

        if (accept) begin
            byte_count_d = byte_count_q + 7'd1;
        end
        if ((state_q == ST_CLEAR) || (state_d == ST_CLEAR)) begin
            byte_count_d = 7'd0;
        end

        if ((state_q == ST_WAIT) && (timeout_cnt_q != 16'hFFFF)) begin
            timeout_cnt_d = timeout_cnt_q + 16'd1;
        end
        if ((state_d == ST_WAIT) && (state_q != ST_WAIT)) begin
            timeout_cnt_d = 16'd0;
        end

        if ((state_q == ST_WAIT) && (state_d == ST_RESULT)) begin
            result_d = bnn_result;
        end
        result_valid_d = (state_d == ST_RESULT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_CLEAR;
            byte_count_q   <= 7'd0;
            result_q       <= 4'd0;
            result_valid_q <= 1'b0;
            err_timeout_q  <= 1'b0;
            timeout_cnt_q  <= 16'd0;
        end else begin
            state_q        <= state_d;
            byte_count_q   <= byte_count_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            err_timeout_q  <= err_timeout_d;
            timeout_cnt_q  <= timeout_cnt_d;
        end
    end

endmodule

// File: tb/tb_image_load_controller.sv
// Directed bench for image_load_controller: buffer writes and results are
// checked by a negedge monitor against queues filled by the stimulus.
module tb_image_load_controller;

    localparam int IMG = 113;
    localparam int TO  = 20;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       cmd_clear;
    logic       buf_clear;
    logic       buf_we;
    logic [7:0] buf_data;
    logic       bnn_start;
    logic       bnn_done;
    logic [3:0] bnn_result;
    logic [3:0] result;
    logic       result_valid;
    logic       result_ack;
    logic       err_timeout;
    logic [6:0] byte_count;
    logic [2:0] state_o;

    image_load_controller #(
        .IMG_BYTES     (IMG),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .cmd_clear   (cmd_clear),
        .buf_clear   (buf_clear),
        .buf_we      (buf_we),
        .buf_data    (buf_data),
        .bnn_start   (bnn_start),
        .bnn_done    (bnn_done),
        .bnn_result  (bnn_result),
        .result      (result),
        .result_valid(result_valid),
        .result_ack  (result_ack),
        .err_timeout (err_timeout),
        .byte_count  (byte_count),
        .state_o     (state_o)
    );

    // Clock and bookkeeping
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_writes = 0;
    int         wait_cnt;
    logic [7:0] exp_q[$];
    logic [3:0] res_q[$];
    logic       rv_prev = 1'b0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Monitor: every buffer write and every new result is matched to the queues
    always @(negedge clk) begin
        if (buf_we) begin
            n_writes++;
            check("write_pending", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                check("buf_data", buf_data, exp_q.pop_front());
            end
        end
        if (result_valid && !rv_prev) begin
            check("result_pending", 32'(res_q.size() > 0), 1);
            if (res_q.size() > 0) begin
                check("result_value", result, res_q.pop_front());
            end
        end
        rv_prev = result_valid;
    end

    // Driver tasks
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic load_frame(input logic [7:0] xr, input bit gapped);
        for (int i = 0; i < IMG; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'(i) ^ xr;
            exp_q.push_back(8'(i) ^ xr);
            next_cycle();
            rx_valid = 1'b0;
            if (gapped && (i != IMG - 1)) begin
                next_cycle();
            end
        end
    endtask

    task automatic ack_result();
        result_ack = 1'b1;
        next_cycle();
        result_ack = 1'b0;
        next_cycle();
    endtask

    initial begin
        rst        = 1'b1;
        rx_valid   = 1'b1;
        rx_data    = 8'h5A;
        cmd_clear  = 1'b0;
        bnn_done   = 1'b0;
        bnn_result = 4'd0;
        result_ack = 1'b0;

        // Reset: outputs held safe even with a byte offered
        repeat (2) next_cycle();
        @(negedge clk);
        check("rst_buf_clear", buf_clear, 1);
        check("rst_rx_ready", rx_ready, 0);
        check("rst_bnn_start", bnn_start, 0);
        check("rst_buf_we", buf_we, 0);
        next_cycle();
        rst      = 1'b0;
        rx_valid = 1'b0;
        @(negedge clk);
        check("post_rst_state", state_o, 0);
        check("post_rst_buf_clear", buf_clear, 1);
        check("post_rst_rx_ready", rx_ready, 0);
        check("post_rst_result", result, 0);
        check("post_rst_rv", result_valid, 0);
        check("post_rst_err", err_timeout, 0);
        check("post_rst_byte_count", byte_count, 0);
        next_cycle();
        @(negedge clk);
        check("load_state", state_o, 1);
        check("load_rx_ready", rx_ready, 1);
        check("load_buf_clear", buf_clear, 0);

        // Full frame back-to-back 0x00..0x70
        n_writes = 0;
        next_cycle();
        load_frame(8'h00, 1'b0);
        @(negedge clk);
        check("full_writes", n_writes, IMG);
        check("start_state", state_o, 2);
        check("start_pulse", bnn_start, 1);
        check("start_byte_count", byte_count, IMG);
        check("start_rx_ready", rx_ready, 0);
        next_cycle();
        @(negedge clk);
        check("wait_state", state_o, 3);
        check("wait_no_start", bnn_start, 0);

        // Result 7, held without ack; a stray bnn_done in RESULT is ignored
        next_cycle();
        bnn_done   = 1'b1;
        bnn_result = 4'd7;
        res_q.push_back(4'd7);
        next_cycle();
        bnn_done = 1'b0;
        for (int k = 0; k < 10; k++) begin
            bnn_done   = (k == 4);
            bnn_result = 4'd3;
            next_cycle();
        end
        bnn_done = 1'b0;
        @(negedge clk);
        check("hold_state", state_o, 4);
        check("hold_result", result, 7);
        check("hold_rv", result_valid, 1);
        check("hold_rx_ready", rx_ready, 0);
        check("hold_byte_count", byte_count, IMG);
        result_ack = 1'b1;
        next_cycle();
        result_ack = 1'b0;
        @(negedge clk);
        check("ack_state", state_o, 0);
        check("ack_buf_clear", buf_clear, 1);
        check("ack_rv", result_valid, 0);
        next_cycle();
        result_ack = 1'b1;
        @(negedge clk);
        check("ack_load_byte_count", byte_count, 0);
        next_cycle();
        result_ack = 1'b0;
        @(negedge clk);
        check("ack_ignored_in_load", state_o, 1);

        // Gapped frame, then a 114th byte offered in START
        n_writes = 0;
        next_cycle();
        load_frame(8'hFF, 1'b1);
        rx_valid = 1'b1;
        rx_data  = 8'hEE;
        @(negedge clk);
        check("extra_rx_ready", rx_ready, 0);
        check("extra_buf_we", buf_we, 0);
        check("extra_state", state_o, 2);
        next_cycle();
        rx_valid = 1'b0;
        @(negedge clk);
        check("gapped_writes", n_writes, IMG);

        // Timeout: no bnn_done for TO cycles
        wait_cnt = 0;
        while (state_o == 3'd3 && wait_cnt < 100) begin
            wait_cnt++;
            next_cycle();
            @(negedge clk);
        end
        check("timeout_wait_cycles", wait_cnt, TO);
        check("timeout_state", state_o, 0);
        check("timeout_err", err_timeout, 1);

        // Error flag survives a whole frame and the auto clear after it
        next_cycle();
        load_frame(8'h3C, 1'b0);
        @(negedge clk);
        check("err_at_start", err_timeout, 1);
        next_cycle();
        bnn_done   = 1'b1;
        bnn_result = 4'd9;
        res_q.push_back(4'd9);
        next_cycle();
        bnn_done = 1'b0;
        @(negedge clk);
        check("frame2_state", state_o, 4);
        check("frame2_err", err_timeout, 1);
        ack_result();
        @(negedge clk);
        check("frame2_load_err", err_timeout, 1);

        // Abort at byte 50 with rx_valid high
        for (int i = 0; i < 50; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'(i + 7);
            exp_q.push_back(8'(i + 7));
            next_cycle();
        end
        cmd_clear = 1'b1;
        rx_data   = 8'hCC;
        @(negedge clk);
        check("abort_byte_count", byte_count, 50);
        check("abort_rx_ready", rx_ready, 0);
        check("abort_buf_we", buf_we, 0);
        next_cycle();
        cmd_clear = 1'b0;
        rx_valid  = 1'b0;
        @(negedge clk);
        check("abort_state", state_o, 0);
        check("abort_err_cleared", err_timeout, 0);
        next_cycle();
        @(negedge clk);
        check("abort_load_state", state_o, 1);
        check("abort_byte_count_zero", byte_count, 0);

        // bnn_done on the last allowed WAIT cycle wins over the timeout
        next_cycle();
        load_frame(8'h55, 1'b0);
        next_cycle();
        repeat (TO - 1) next_cycle();
        bnn_done   = 1'b1;
        bnn_result = 4'd4;
        res_q.push_back(4'd4);
        @(negedge clk);
        check("edge_still_wait", state_o, 3);
        next_cycle();
        bnn_done = 1'b0;
        @(negedge clk);
        check("edge_state", state_o, 4);
        check("edge_err", err_timeout, 0);
        check("edge_result", result, 4);
        ack_result();

        // Reset mid-WAIT, with cmd_clear and a byte also present
        load_frame(8'hA0, 1'b0);
        repeat (6) next_cycle();
        rst       = 1'b1;
        cmd_clear = 1'b1;
        rx_valid  = 1'b1;
        next_cycle();
        @(negedge clk);
        check("midrst_buf_clear", buf_clear, 1);
        check("midrst_rx_ready", rx_ready, 0);
        check("midrst_buf_we", buf_we, 0);
        check("midrst_state", state_o, 0);
        check("midrst_result", result, 0);
        check("midrst_rv", result_valid, 0);
        check("midrst_byte_count", byte_count, 0);
        next_cycle();
        rst        = 1'b0;
        cmd_clear  = 1'b0;
        rx_valid   = 1'b0;
        bnn_done   = 1'b1;
        bnn_result = 4'd8;
        repeat (2) next_cycle();
        @(negedge clk);
        check("late_done_state", state_o, 1);
        check("late_done_rv", result_valid, 0);
        check("late_done_result", result, 0);
        bnn_done = 1'b0;

        next_cycle();
        @(negedge clk);
        check("writes_drained", exp_q.size(), 0);
        check("results_drained", res_q.size(), 0);
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
